// File: rtl/core_dispatch_rx.sv
// rtl/core_dispatch_rx.sv - core-side frame dispatch receiver
// Pulls a frame's instruction words from the scheduler into a FIFO and hands them to the core.
module core_dispatch_rx #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 6
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_frame_start,
  input  logic             i_core_sel,
  input  logic             i_init_r0,
  input  logic [CNT_W-1:0] i_if_num,
  output logic             o_core_read_f,
  input  logic             i_mess_valid,
  input  logic [31:0]      i_mess_to_core,
  output logic             o_instr_valid,
  output logic [31:0]      o_instr_data,
  input  logic             i_instr_ready,
  output logic             o_r0_init_valid,
  output logic             o_r0_init_val,
  input  logic             i_core_busy,
  output logic             o_core_done,
  output logic             o_busy,
  output logic             o_proto_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_remaining, r_requested, r_received;
  logic             r_outstanding;
  logic             r_r0_init_valid, r_r0_init_val, r_proto_err;
  logic [AW:0]      r_wr_ptr, r_rd_ptr;
  logic [31:0]      r_mem [DEPTH];

  logic        w_start, w_empty, w_full, w_pop, w_push, w_wr;
  logic [AW:0] w_count;

  assign w_start = i_frame_start && i_core_sel && (r_state == S_IDLE);
  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = !w_empty && i_instr_ready;
  assign w_push  = i_mess_valid && r_outstanding;
  assign w_wr    = w_push && (!w_full || w_pop);

  // A request reserves its FIFO slot, so a later push can never overflow.
  assign o_core_read_f = (r_state == S_FETCH) && !r_outstanding && (r_requested < r_remaining) &&
                         ((w_count + {{AW{1'b0}}, r_outstanding}) < DEPTH_W);

  assign o_instr_valid   = !w_empty;
  assign o_instr_data    = w_empty ? 32'd0 : r_mem[r_rd_ptr[AW-1:0]];
  assign o_r0_init_valid = r_r0_init_valid;
  assign o_r0_init_val   = r_r0_init_val;
  assign o_core_done     = (r_state == S_DONE);
  assign o_busy          = (r_state != S_IDLE);
  assign o_proto_err     = r_proto_err;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next = (i_if_num == '0) ? S_DONE : S_FETCH;
      S_FETCH: if (r_received == r_remaining) w_next = S_DRAIN;
      S_DRAIN: if (w_empty && !i_core_busy) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_remaining     <= '0;
      r_requested     <= '0;
      r_received      <= '0;
      r_outstanding   <= 1'b0;
      r_r0_init_valid <= 1'b0;
      r_r0_init_val   <= 1'b0;
      r_proto_err     <= 1'b0;
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
    end else begin
      r_r0_init_valid <= w_start;
      if (w_start) begin
        r_remaining   <= i_if_num;
        r_requested   <= '0;
        r_received    <= '0;
        r_r0_init_val <= i_init_r0;
      end
      if (o_core_read_f) begin
        r_outstanding <= 1'b1;
        r_requested   <= r_requested + 1'b1;
      end
      if (w_push) r_outstanding <= 1'b0;
      if (w_wr) begin
        r_received <= r_received + 1'b1;
        r_wr_ptr   <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if ((i_frame_start && r_state != S_IDLE) || (i_mess_valid && !r_outstanding))
        r_proto_err <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_mess_to_core;
  end

endmodule

// File: tb/tb_core_dispatch_rx.sv
// tb/tb_core_dispatch_rx.sv - self-checking bench for core_dispatch_rx
// Directed frames with a responding scheduler and a queue-based reference model.
module tb_core_dispatch_rx;

  localparam int DEPTH = 4;
  localparam int CNT_W = 6;

  logic             clk, rst_n, frame_start, core_sel, init_r0;
  logic [CNT_W-1:0] if_num;
  logic             mess_valid, instr_ready, core_busy;
  logic [31:0]      mess_to_core;
  logic             o_core_read_f, o_instr_valid, o_r0_init_valid, o_r0_init_val;
  logic             o_core_done, o_busy, o_proto_err;
  logic [31:0]      o_instr_data;

  int n_tests, n_fail;
  int cnt_reads, cnt_done, cnt_r0;
  logic [31:0] log_q[$];

  int m_phase, m_rem, m_req, m_rcv, m_out, m_rcv_pre;
  logic m_err, m_r0v, m_r0val, exp_rd, q_empty_now;
  logic [31:0] m_q[$];

  logic [31:0] word_base;
  int base_mark, resp_total, stray_cnt, stray_done;
  logic req_seen;

  core_dispatch_rx #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_frame_start(frame_start), .i_core_sel(core_sel),
    .i_init_r0(init_r0), .i_if_num(if_num), .o_core_read_f(o_core_read_f),
    .i_mess_valid(mess_valid), .i_mess_to_core(mess_to_core), .o_instr_valid(o_instr_valid),
    .o_instr_data(o_instr_data), .i_instr_ready(instr_ready), .o_r0_init_valid(o_r0_init_valid),
    .o_r0_init_val(o_r0_init_val), .i_core_busy(core_busy), .o_core_done(o_core_done),
    .o_busy(o_busy), .o_proto_err(o_proto_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scheduler: answers each request one cycle later; can also inject an unrequested word.
  initial begin
    mess_valid = 1'b0;
    mess_to_core = '0;
    resp_total = 0;
    stray_done = 0;
    forever begin
      @(negedge clk);
      req_seen = rst_n && o_core_read_f;
      @(posedge clk);
      #1;
      if (req_seen) begin
        mess_valid = 1'b1;
        mess_to_core = word_base + 32'(resp_total - base_mark);
        resp_total++;
      end else if (stray_cnt != stray_done) begin
        mess_valid = 1'b1;
        mess_to_core = 32'hDEADBEEF;
        stray_done++;
      end else begin
        mess_valid = 1'b0;
        mess_to_core = '0;
      end
    end
  end

  // Reference model: checks this cycle's outputs, then advances on this cycle's inputs.
  initial begin
    n_tests = 0; n_fail = 0; cnt_reads = 0; cnt_done = 0; cnt_r0 = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_outs", 32'({o_core_read_f, o_instr_valid, o_r0_init_valid, o_r0_init_val,
                             o_core_done, o_busy, o_proto_err}), 32'd0);
        chk("rst_data", o_instr_data, 32'd0);
        m_phase = 0; m_rem = 0; m_req = 0; m_rcv = 0; m_out = 0;
        m_err = 1'b0; m_r0v = 1'b0; m_r0val = 1'b0;
        m_q.delete();
      end else begin
        exp_rd = (m_phase == 1) && (m_out == 0) && (m_req < m_rem) && ((m_q.size() + m_out) < DEPTH);
        chk("core_read_f", 32'(o_core_read_f), 32'(exp_rd));
        n_tests++;
        ovf: assert (!(o_core_read_f && (m_q.size() + m_out) >= DEPTH)) else begin
          n_fail++;
          $display("FAIL overflow: request with %0d words held", m_q.size() + m_out);
        end
        chk("instr_valid", 32'(o_instr_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) chk("instr_data", o_instr_data, m_q[0]);
        chk("r0_init_valid", 32'(o_r0_init_valid), 32'(m_r0v));
        chk("r0_init_val", 32'(o_r0_init_val), 32'(m_r0val));
        chk("core_done", 32'(o_core_done), 32'(m_phase == 3));
        chk("busy", 32'(o_busy), 32'(m_phase != 0));
        chk("proto_err", 32'(o_proto_err), 32'(m_err));

        cnt_reads += int'(o_core_read_f);
        cnt_done  += int'(o_core_done);
        cnt_r0    += int'(o_r0_init_valid);
        if (o_instr_valid && instr_ready) log_q.push_back(o_instr_data);

        q_empty_now = (m_q.size() == 0);
        m_rcv_pre = m_rcv;
        if (!q_empty_now && instr_ready) void'(m_q.pop_front());
        if (mess_valid) begin
          if (m_out != 0) begin
            m_q.push_back(mess_to_core);
            m_out = 0;
            m_rcv++;
          end else m_err = 1'b1;
        end
        if (exp_rd) begin
          m_out = 1;
          m_req++;
        end
        if (frame_start && m_phase != 0) m_err = 1'b1;
        m_r0v = 1'b0;
        case (m_phase)
          0: if (frame_start && core_sel) begin
               m_rem = int'(if_num); m_req = 0; m_rcv = 0;
               m_r0v = 1'b1; m_r0val = init_r0;
               m_phase = (if_num == 0) ? 3 : 1;
             end
          1: if (m_rcv_pre == m_rem) m_phase = 2;
          2: if (q_empty_now && !core_busy) m_phase = 3;
          default: m_phase = 0;
        endcase
      end
    end
  end

  task automatic start(logic sel, logic r0, int n);
    frame_start = 1'b1; core_sel = sel; init_r0 = r0; if_num = CNT_W'(n);
    cyc(1);
    frame_start = 1'b0; core_sel = 1'b0; init_r0 = 1'b0; if_num = '0;
  endtask

  task automatic wait_idle(string nm, int budget);
    for (int i = 0; i < budget && o_busy; i++) cyc(1);
    chk({nm, "_timeout"}, 32'(o_busy), 32'd0);
  endtask

  task automatic set_words(logic [31:0] base);
    word_base = base;
    base_mark = resp_total;
  endtask

  task automatic chk_words(string nm, int mark, logic [31:0] base, int n);
    chk({nm, "_count"}, 32'(log_q.size() - mark), 32'(n));
    for (int i = 0; i < n; i++)
      chk({nm, "_word"}, (mark + i < log_q.size()) ? log_q[mark + i] : 32'hFFFF_FFFF,
          base + 32'(i));
  endtask

  int rd0, dn0, r00, lg0;
  task automatic mark_all();
    rd0 = cnt_reads; dn0 = cnt_done; r00 = cnt_r0; lg0 = log_q.size();
  endtask

  initial begin
    rst_n = 1'b0; frame_start = 1'b0; core_sel = 1'b0; init_r0 = 1'b0; if_num = '0;
    instr_ready = 1'b0; core_busy = 1'b0; stray_cnt = 0;
    word_base = '0; base_mark = 0;
    cyc(3);
    chk("reset_busy", 32'(o_busy), 32'd0);
    chk("reset_valid", 32'(o_instr_valid), 32'd0);
    chk("reset_err", 32'(o_proto_err), 32'd0);
    rst_n = 1'b1;
    cyc(2);

    // Basic 3-word frame
    mark_all(); set_words(32'hA0000001); instr_ready = 1'b1;
    start(1'b1, 1'b1, 3);
    wait_idle("t1", 100);
    chk("t1_reads", 32'(cnt_reads - rd0), 32'd3);
    chk("t1_done", 32'(cnt_done - dn0), 32'd1);
    chk("t1_r0_pulse", 32'(cnt_r0 - r00), 32'd1);
    chk("t1_r0_val", 32'(o_r0_init_val), 32'd1);
    chk_words("t1", lg0, 32'hA0000001, 3);
    cyc(2);

    // Back-pressure: 10 words through a 4-deep FIFO
    mark_all(); set_words(32'hB0000000); instr_ready = 1'b0;
    start(1'b1, 1'b0, 10);
    cyc(40);
    chk("t2_reads_stalled", 32'(cnt_reads - rd0), 32'd4);
    chk("t2_valid_stalled", 32'(o_instr_valid), 32'd1);
    instr_ready = 1'b1;
    wait_idle("t2", 200);
    chk("t2_reads", 32'(cnt_reads - rd0), 32'd10);
    chk("t2_done", 32'(cnt_done - dn0), 32'd1);
    chk_words("t2", lg0, 32'hB0000000, 10);
    cyc(2);

    // Not selected, then an empty frame
    mark_all();
    start(1'b0, 1'b1, 5);
    cyc(5);
    chk("t3_reads", 32'(cnt_reads - rd0), 32'd0);
    chk("t3_busy", 32'(o_busy), 32'd0);
    chk("t3_r0", 32'(cnt_r0 - r00), 32'd0);
    mark_all();
    start(1'b1, 1'b0, 0);
    cyc(3);
    chk("t3_zero_done", 32'(cnt_done - dn0), 32'd1);
    chk("t3_zero_r0", 32'(cnt_r0 - r00), 32'd1);
    chk("t3_zero_reads", 32'(cnt_reads - rd0), 32'd0);
    chk("t3_zero_busy", 32'(o_busy), 32'd0);

    // Protocol errors mid-frame
    mark_all(); set_words(32'hC0000000);
    start(1'b1, 1'b0, 6);
    cyc(2);
    start(1'b1, 1'b1, 2);
    stray_cnt++;
    wait_idle("t4", 200);
    chk("t4_err", 32'(o_proto_err), 32'd1);
    chk("t4_reads", 32'(cnt_reads - rd0), 32'd6);
    chk("t4_done", 32'(cnt_done - dn0), 32'd1);
    chk_words("t4", lg0, 32'hC0000000, 6);
    cyc(5);
    chk("t4_err_sticky", 32'(o_proto_err), 32'd1);

    // Core still busy after the FIFO drains
    mark_all(); set_words(32'hD0000000); core_busy = 1'b1;
    start(1'b1, 1'b0, 2);
    for (int i = 0; i < 100 && log_q.size() < lg0 + 2; i++) cyc(1);
    chk("t5_words", 32'(log_q.size() - lg0), 32'd2);
    cyc(20);
    chk("t5_no_done", 32'(cnt_done - dn0), 32'd0);
    chk("t5_busy", 32'(o_busy), 32'd1);
    core_busy = 1'b0;
    cyc(1);
    chk("t5_done_now", 32'(o_core_done), 32'd1);
    cyc(1);
    chk("t5_done_gone", 32'(o_core_done), 32'd0);
    chk("t5_idle", 32'(o_busy), 32'd0);

    // Reset in the middle of a fetch
    set_words(32'hE0000000); instr_ready = 1'b0;
    start(1'b1, 1'b0, 8);
    cyc(6);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_outs", 32'({o_core_read_f, o_instr_valid, o_r0_init_valid, o_r0_init_val,
                            o_core_done, o_busy, o_proto_err}), 32'd0);
    chk("t6_rst_data", o_instr_data, 32'd0);
    cyc(2);
    rst_n = 1'b1;
    instr_ready = 1'b1;
    cyc(3);
    chk("t6_empty", 32'(o_instr_valid), 32'd0);
    chk("t6_idle", 32'(o_busy), 32'd0);
    chk("t6_err_clear", 32'(o_proto_err), 32'd0);
    mark_all(); set_words(32'hF0000000);
    start(1'b1, 1'b1, 2);
    wait_idle("t6", 100);
    chk_words("t6", lg0, 32'hF0000000, 2);
    chk("t6_err_after", 32'(o_proto_err), 32'd0);
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
